// File: rtl/fetch_queue.sv
// Instruction fetch front-end: sequential word fetches, in-order response buffering and branch redirect.
// Optional performance counters are enabled with `define FETCH_QUEUE_PERF_EN.
module fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_dropped,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_S   = SW'(DEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   respPc_q, respPc_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] dropCnt_q, dropCnt_d;
  logic [31:0]   instrMem_q [DEPTH];
  logic [31:0]   pcMem_q [DEPTH];

  logic          reqFire;
  logic          dropResp;
  logic          push;
  logic          pop;
  logic [SW-1:0] inFlight;
  logic [31:0]   redirectTarget;

  // Issue only when the FIFO has room reserved for every in-flight response.
  always_comb begin
    inFlight       = {1'b0, count_q} + {1'b0, outstanding_q};
    imem_req_valid = !rst && !redirect && (inFlight < DEPTH_S) && (outstanding_q < MAX_OUT_C);
    imem_req_addr  = fetchPc_q;
    out_valid      = !rst && (count_q != '0);
    out_instr      = instrMem_q[rdPtr_q];
    out_pc         = pcMem_q[rdPtr_q];
    reqFire        = imem_req_valid && imem_req_ready;
    dropResp       = imem_resp_valid && (redirect || (dropCnt_q != '0));
    push           = imem_resp_valid && !dropResp;
    pop            = out_valid && out_ready && !redirect;
    redirectTarget = redirect_pc & 32'hFFFF_FFFC;
  end

  always_comb begin
    fetchPc_d     = fetchPc_q;
    respPc_d      = respPc_q;
    rdPtr_d       = rdPtr_q;
    wrPtr_d       = wrPtr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    dropCnt_d     = dropCnt_q;
    if (redirect) begin
      // Every request still unanswered after this cycle returns stale data.
      fetchPc_d     = redirectTarget;
      respPc_d      = redirectTarget;
      rdPtr_d       = '0;
      wrPtr_d       = '0;
      count_d       = '0;
      outstanding_d = outstanding_q - CW'(imem_resp_valid);
      dropCnt_d     = outstanding_q - CW'(imem_resp_valid);
    end else begin
      if (reqFire) begin
        fetchPc_d = fetchPc_q + 32'd4;
      end
      if (push) begin
        respPc_d = respPc_q + 32'd4;
        wrPtr_d  = wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      if (dropResp) begin
        dropCnt_d = dropCnt_q - CW'(1);
      end
      count_d       = count_q + CW'(push) - CW'(pop);
      outstanding_d = outstanding_q + CW'(reqFire) - CW'(imem_resp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc_q     <= RESET_PC;
      respPc_q      <= RESET_PC;
      rdPtr_q       <= '0;
      wrPtr_q       <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      respPc_q      <= respPc_d;
      rdPtr_q       <= rdPtr_d;
      wrPtr_q       <= wrPtr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instrMem_q[wrPtr_q] <= imem_resp_data;
      pcMem_q[wrPtr_q]    <= respPc_q;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perfRedirects_q;
  logic [31:0] perfDropped_q;
  logic [31:0] perfStall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perfRedirects_q <= '0;
      perfDropped_q   <= '0;
      perfStall_q     <= '0;
    end else begin
      if (redirect) begin
        perfRedirects_q <= perfRedirects_q + 32'd1;
      end
      if (dropResp) begin
        perfDropped_q <= perfDropped_q + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perfStall_q <= perfStall_q + 32'd1;
      end
    end
  end

  assign perf_redirects    = perfRedirects_q;
  assign perf_dropped      = perfDropped_q;
  assign perf_stall_cycles = perfStall_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus stall, stale-drop and reset sequences.
// A small in-order memory model with programmable latency answers the fetch requests.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_dropped;
  logic [31:0] perf_stall_cycles;
`endif

  fetch_queue #(
    .DEPTH(4),
    .MAX_OUTSTANDING(2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_redirects(perf_redirects),
    .perf_dropped(perf_dropped),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  typedef struct {
    logic        rstIn;
    logic        redirectIn;
    logic [31:0] redirectPcIn;
    logic        outReadyIn;
    logic        expReqValid;
    logic [31:0] expReqAddr;
    logic        expOutValid;
    logic [31:0] expOutPc;
  } vec_t;

  vec_t        vecs [17];
  int          total = 0;
  int          bad = 0;
  int          memLatency = 1;
  int          fireCount = 0;
  int          negIdx = 0;
  logic [31:0] pendAddr [$];
  int          pendDue [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Memory model: requests seen at a falling edge are accepted at the next rising edge
  // and answered memLatency cycles later, in order; reset clears anything in flight.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      negIdx++;
      if (rst) begin
        pendAddr.delete();
        pendDue.delete();
        imem_resp_valid = 1'b0;
      end else begin
        if (pendDue.size() > 0 && pendDue[0] == negIdx) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = instrOf(pendAddr[0]);
          void'(pendAddr.pop_front());
          void'(pendDue.pop_front());
        end else begin
          imem_resp_valid = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) begin
          pendAddr.push_back(imem_req_addr);
          pendDue.push_back(negIdx + memLatency);
          fireCount++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, return at the falling edge for sampling.
  task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] rpc,
                               input logic ordy, input logic qrdy);
    @(posedge clk);
    #1;
    rst            = r;
    redirect       = rd;
    redirect_pc    = rpc;
    out_ready      = ordy;
    imem_req_ready = qrdy;
    @(negedge clk);
  endtask

  task automatic stallTest();
    logic [31:0] popped [$];
    int base;
    memLatency = 1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    #2;
    base = fireCount;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      if (out_valid) checkOutput("stall head pc", out_pc, 32'h0);
    end
    checkOutput("stall req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("stall out_valid", 32'(out_valid), 32'd1);
    #2;
    checkOutput("stall accepted requests", 32'(fireCount - base), 32'd4);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (out_valid) begin
        popped.push_back(out_pc);
        checkOutput("stall drain instr", out_instr, instrOf(out_pc));
      end
    end
    checkOutput("stall drain count ok", 32'(popped.size() >= 4), 32'd1);
    if (popped.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("stall drain pc%0d", k), popped[k], 32'(4 * k));
      end
    end
  endtask

  task automatic dropTest();
    logic [31:0] popped [$];
    int mark;
    int stale;
    memLatency = 3;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (out_valid) popped.push_back(out_pc);
    end
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1);
    checkOutput("drop redirect req_valid", 32'(imem_req_valid), 32'd0);
    mark = popped.size();
    for (int c = 8; c <= 25; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (out_valid) begin
        popped.push_back(out_pc);
        checkOutput("drop instr", out_instr, instrOf(out_pc));
      end
    end
    checkOutput("drop pre-redirect pops", 32'(mark), 32'd2);
    if (mark == 2) begin
      checkOutput("drop pre pc0", popped[0], 32'h0);
      checkOutput("drop pre pc1", popped[1], 32'h4);
    end
    checkOutput("drop post pops ok", 32'(popped.size() >= mark + 2), 32'd1);
    if (popped.size() >= mark + 2) begin
      checkOutput("drop first new pc", popped[mark], 32'h0000_0100);
      checkOutput("drop second new pc", popped[mark + 1], 32'h0000_0104);
    end
    stale = 0;
    foreach (popped[k]) begin
      if (popped[k] == 32'h8 || popped[k] == 32'hC) stale++;
    end
    checkOutput("drop stale entries seen", 32'(stale), 32'd0);
  endtask

  task automatic resetTest();
    memLatency = 3;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    checkOutput("rst pre out_valid", 32'(out_valid), 32'd1);
    checkOutput("rst pre out_pc", out_pc, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rst during req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst during out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("rst after out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst after req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("rst after req_addr", imem_req_addr, 32'h0);
`ifdef FETCH_QUEUE_PERF_EN
    checkOutput("rst perf_redirects", perf_redirects, 32'h0);
    checkOutput("rst perf_dropped", perf_dropped, 32'h0);
    checkOutput("rst perf_stall_cycles", perf_stall_cycles, 32'h0);
`endif
    for (int c = 9; c <= 12; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    checkOutput("rst refill out_valid", 32'(out_valid), 32'd1);
    checkOutput("rst refill out_pc", out_pc, 32'h0);
  endtask

  initial begin
    rst            = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;

    // Latency-1 memory, decode always ready: streaming, then a misaligned redirect
    // colliding with a response and a pop, then a redirect that wraps the address space.
    vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         1'b1, 32'h4};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b1, 32'h8};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14,        1'b1, 32'hC};
    vecs[7]  = '{1'b0, 1'b1, 32'h203,       1'b1, 1'b0, 32'h0,         1'b1, 32'h10};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h200,       1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h204,       1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h208,       1'b1, 32'h200};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h0,         1'b1, 32'h204};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFF8};
    vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b1, 32'hFFFF_FFFC};
    vecs[16] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b1, 32'h0};

    memLatency = 1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rstIn, vecs[i].redirectIn, vecs[i].redirectPcIn, vecs[i].outReadyIn, 1'b1);
      checkOutput($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].expReqValid));
      if (vecs[i].expReqValid) begin
        checkOutput($sformatf("vec%0d req_addr", i), imem_req_addr, vecs[i].expReqAddr);
      end
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].expOutValid));
      if (vecs[i].expOutValid) begin
        checkOutput($sformatf("vec%0d out_pc", i), out_pc, vecs[i].expOutPc);
        checkOutput($sformatf("vec%0d out_instr", i), out_instr, instrOf(vecs[i].expOutPc));
      end
    end

    $display("[TB] stall sequence");
    stallTest();
    $display("[TB] stale-drop sequence");
    dropTest();
    $display("[TB] reset sequence");
    resetTest();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
